// File: rtl/gate_tt_checker.sv
// Sequential BIST engine for 2-input gates: walks {a,b} through 00..11, samples c
// after a settle interval and compares against truth table TT. Optional macro GATE_CHK_MASK_EN adds fail_mask.
module gate_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter logic [3:0]  TT            = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_idx
`ifdef GATE_CHK_MASK_EN
  ,
  output logic [3:0] fail_mask
`endif
);

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] err_n;
  logic [1:0] fidx_n;
  logic       first_fail, first_n;
  logic       mismatch;
  logic [1:0] ab_n;
  logic       busy_n, done_n, pass_n;
`ifdef GATE_CHK_MASK_EN
  logic [3:0] mask_n;
`endif

  // State and result registers; a/b/status are registered from next-state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 8'd0;
      err_count  <= 3'd0;
      fail_idx   <= 2'd0;
      first_fail <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef GATE_CHK_MASK_EN
      fail_mask  <= 4'd0;
`endif
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      err_count  <= err_n;
      fail_idx   <= fidx_n;
      first_fail <= first_n;
      {a, b}     <= ab_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
`ifdef GATE_CHK_MASK_EN
      fail_mask  <= mask_n;
`endif
    end
  end

  assign mismatch = c ^ TT[idx];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    err_n   = err_count;
    fidx_n  = fail_idx;
    first_n = first_fail;
`ifdef GATE_CHK_MASK_EN
    mask_n  = fail_mask;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SETTLE;
          idx_n   = 2'd0;
          cnt_n   = CNT_INIT;
          err_n   = 3'd0;
          fidx_n  = 2'd0;
          first_n = 1'b0;
`ifdef GATE_CHK_MASK_EN
          mask_n  = 4'd0;
`endif
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) state_n = SAMPLE;
        else             cnt_n   = cnt - 8'd1;
      end
      SAMPLE: begin
        // At most four increments per run, so the 3-bit count cannot wrap.
        if (mismatch) begin
          err_n = err_count + 3'd1;
          if (!first_fail) begin
            fidx_n  = idx;
            first_n = 1'b1;
          end
`ifdef GATE_CHK_MASK_EN
          mask_n[idx] = 1'b1;
`endif
        end
        if (idx == 2'd3) begin
          state_n = DONE;
        end else begin
          state_n = SETTLE;
          idx_n   = idx + 2'd1;
          cnt_n   = CNT_INIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_n = (state_n == SETTLE) || (state_n == SAMPLE);
    ab_n   = busy_n ? idx_n : 2'b00;
    done_n = (state_n == DONE);
    pass_n = done_n && (err_n == 3'd0);
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: OR/AND/stuck-1 gate models, timing, reset and restart.
module tb_gate_tt_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_idx;
`ifdef GATE_CHK_MASK_EN
  logic [3:0] fail_mask;
`endif
  int         gate_sel = 0;
  int         npass = 0;
  int         ntotal = 0;

  gate_tt_checker #(.SETTLE_CYCLES(10), .TT(4'b1110)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx)
`ifdef GATE_CHK_MASK_EN
    , .fail_mask(fail_mask)
`endif
  );

  always #5 clk = ~clk;

  // Gate under test: 0=OR, 1=AND, 2=stuck at 1
  always_comb begin
    case (gate_sel)
      1:       c = a & b;
      2:       c = 1'b1;
      default: c = a | b;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Accept edge counts as edge 1; vector k holds for 11 edges; done must rise at edge 45.
  task automatic run_full(input bit inject);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("accept_state", {busy, done, pass, a, b}, 8'b10000);
    chk("accept_err_clear", {3'b0, err_count, fail_idx}, 8'h00);
    for (int k = 2; k <= 45; k++) begin
      if (inject && (k == 6 || k == 30)) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (k <= 44)
        chk($sformatf("run_edge%0d", k), {4'b0, busy, done, a, b}, {4'b0, 1'b1, 1'b0, 2'((k - 1) / 11)});
      else
        chk("done_edge45", {4'b0, busy, done, a, b}, 8'b0100);
    end
  endtask

  initial begin
    #1;
    chk("reset_outputs", {busy, done, pass, a, b}, 8'h00);
    chk("reset_results", {3'b0, err_count, fail_idx}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", {busy, done, a, b}, 8'h00);

    // OR gate, with start pulses while busy
    gate_sel = 0;
    run_full(1'b1);
    chk("or_result", {pass, err_count, fail_idx}, 8'b1_000_00);
    repeat (5) @(posedge clk);
    #1 chk("or_done_hold", {done, pass, err_count}, 8'b1_1_000);

    // AND gate from DONE: mismatches at 01 and 10
    gate_sel = 1;
    run_full(1'b0);
    chk("and_result", {pass, err_count, fail_idx}, 8'b0_010_01);
`ifdef GATE_CHK_MASK_EN
    chk("and_mask", {4'b0, fail_mask}, 8'b0110);
`endif

    // Swap back to OR from DONE: results clear on the start edge
    gate_sel = 0;
    run_full(1'b0);
    chk("reswap_or_result", {pass, err_count, fail_idx}, 8'b1_000_00);
`ifdef GATE_CHK_MASK_EN
    chk("reswap_or_mask", {4'b0, fail_mask}, 8'b0000);
`endif

    // c stuck at 1: only vector 00 mismatches
    gate_sel = 2;
    run_full(1'b0);
    chk("stuck1_result", {pass, err_count, fail_idx}, 8'b0_001_00);
`ifdef GATE_CHK_MASK_EN
    chk("stuck1_mask", {4'b0, fail_mask}, 8'b0001);
`endif

    // AND again so the mid-run abort happens with errors already accumulated
    gate_sel = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 chk("midrun_busy", {busy, a, b}, 8'b101);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {busy, done, pass, a, b}, 8'h00);
    chk("async_reset_results", {3'b0, err_count, fail_idx}, 8'h00);
`ifdef GATE_CHK_MASK_EN
    chk("async_reset_mask", {4'b0, fail_mask}, 8'h00);
`endif
    @(negedge clk); rst_n = 1'b1;
    gate_sel = 0;
    run_full(1'b0);
    chk("post_reset_or_result", {pass, err_count, fail_idx}, 8'b1_000_00);

    // start with reset asserted: reset wins
    @(negedge clk); rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("start_during_reset", {busy, done, pass, a, b}, 8'h00);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, done}, 8'h00);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Sequential built-in self-test engine for 2-input logic gates. It drives every input combination into a gate, waits a settle interval, samples the gate output and compares it against a programmable truth table.
- It owns both ends of the gate interface: it generates stimulus on a/b and checks the response on c.
- It sits beside any gate instance in the gates library and reports pass/fail plus an error count and the first failing vector.

Parameters:
- SETTLE_CYCLES, 10: clock cycles each vector is held before c is sampled; legal range 1..255.
- TT, 4'b1110: expected truth table. Bit i is the expected c for {a,b}=i. The default is OR.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a run when sampled high in IDLE or DONE.
- a  output  1  gate input A stimulus.
- b  output  1  gate input B stimulus.
- c  input  1  gate output under test; synchronous to clk for sampling purposes.
- busy  output  1  high while a run is in progress (SETTLE or SAMPLE).
- done  output  1  high while in DONE; held until the next start or reset.
- pass  output  1  high in DONE when err_count==0; low otherwise.
- err_count  output  3  number of mismatching vectors in the last run, 0..4.
- fail_idx  output  2  {a,b} index of the first mismatch in the last run; 0 if none.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, cnt=0, a=b=0, busy=done=pass=0, err_count=0, fail_idx=0.
- States:
  - IDLE:
    - a=b=0.
    - On start=1, clear err_count, fail_idx and the first-fail flag; set idx=0, cnt=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE:
    - {a,b}=idx.
    - If cnt==0, go to SAMPLE; else cnt--.
    - Occupies exactly SETTLE_CYCLES cycles per vector.
  - SAMPLE: occupies 1 cycle. At the edge:
    - Compare c with TT[idx].
    - On mismatch: err_count++; if this is the first mismatch, latch fail_idx=idx.
    - If idx==3, go to DONE; else idx++, cnt=SETTLE_CYCLES-1, go to SETTLE.
  - DONE:
    - a=b=0, done=1; pass=(err_count==0).
    - Results stay stable.
    - start=1 begins a new run exactly as from IDLE, clearing results on that edge.
- busy=1 in SETTLE and SAMPLE only. start is ignored while busy.
- Latency: done rises on rising edge number 4*(SETTLE_CYCLES+1)+1 after the edge that accepts start. This is edge 45 for the default parameters.
- a/b change only on state-transition edges and never glitch within a vector.
- err_count is 3 bits wide and saturates naturally at 4; it never wraps.
- Reset mid-run aborts immediately to reset values. No partial results are retained.
- Simultaneous start and rst_n low: reset wins.

Optional Feature:
- Macro GATE_CHK_MASK_EN.
- Defined: adds output port fail_mask [3:0].
  - Bit i is set when vector i mismatched in the last run.
  - Cleared on reset and on run start; stable in DONE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- OR gate on a/b->c, TT=4'b1110, pulse start -> done=1 at edge 45; pass=1, err_count=0, fail_idx=0.
- AND gate substituted, TT=4'b1110 -> err_count=2, fail_idx=1, pass=0. With GATE_CHK_MASK_EN: fail_mask=4'b0110.
- c tied 1, TT=4'b1110 -> err_count=1, fail_idx=0, pass=0. With the macro: fail_mask=4'b0001.
- Vector timing: during the run, {a,b} holds 00, 01, 10, 11 for 11 cycles each; start pulses while busy are ignored and the run still completes at edge 45.
- rst_n low at cycle 20 of a run -> all outputs zero immediately and state IDLE. A new start then completes normally at edge 45.
- From DONE with the AND gate (err_count=2), swap in the OR gate and pulse start -> err_count clears on the start edge; the final result is pass=1, err_count=0.
